// File: rtl/mux_stim_checker.sv
// Exhaustive stimulus generator and checker for an external 2:1 mux.
// Build option: define MUX_PROBE_FULL_CHECK_EN to check all nine probe bits instead of probe[8] only.

module mux_stim_checker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [8:0] probe,
    output logic       S,
    output logic       I0,
    output logic       I1,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [7:0] fail_vec
);

    // state  | meaning
    // IDLE   | waiting for start after reset, stimulus parked at 0
    // DRIVE  | vector v presented to the mux, settling cycle
    // SAMPLE | vector v still presented, probe compared and result recorded
    // DONE   | sweep complete, results held until next start or reset
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] v_q, v_d;
    logic [3:0] err_q, err_d;
    logic [7:0] fail_q, fail_d;
    logic       drv_active;
    logic [8:0] exp_probe;
    logic       mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            v_q     <= 3'd0;
            err_q   <= 4'd0;
            fail_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign drv_active = (state_q == DRIVE) || (state_q == SAMPLE);
    assign S          = drv_active & v_q[2];
    assign I1         = drv_active & v_q[1];
    assign I0         = drv_active & v_q[0];

    assign exp_probe = {(S ? I1 : I0), I0, (I1 & S), 1'b1, S, S, S, I1, I0};

`ifdef MUX_PROBE_FULL_CHECK_EN
    assign mismatch = (probe != exp_probe);
`else
    assign mismatch = (probe[8] != exp_probe[8]);
    // Lower probe bits are deliberately not checked in this build.
    logic unused_probe_bits;
    assign unused_probe_bits = ^{probe[7:0], exp_probe[7:0]};
`endif

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        err_d   = err_q;
        fail_d  = fail_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                    v_d     = 3'd0;
                    err_d   = 4'd0;
                    fail_d  = 8'd0;
                end
            end
            DRIVE: begin
                state_d = SAMPLE;
            end
            SAMPLE: begin
                if (mismatch) begin
                    fail_d[v_q] = 1'b1;
                    err_d       = err_q + 4'd1;
                end
                if (v_q == 3'd7) begin
                    state_d = DONE;
                end else begin
                    v_d     = v_q + 3'd1;
                    state_d = DRIVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = drv_active;
    assign done     = (state_q == DONE);
    assign pass     = done && (err_q == 4'd0);
    assign err_cnt  = err_q;
    assign fail_vec = fail_q;

endmodule

// File: tb/tb_mux_stim_checker.sv
// Directed bench for mux_stim_checker: behavioural mux with selectable faults, result scoreboard.
// Expected results follow MUX_PROBE_FULL_CHECK_EN the same way the design does.

module tb_mux_stim_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [8:0] probe;
    logic       S, I0, I1;
    logic       busy, done, pass;
    logic [3:0] err_cnt;
    logic [7:0] fail_vec;

    int mode;
    int errors;
    int checks;

    typedef struct packed {
        logic [7:0] fv;
        logic [3:0] ec;
        logic       ps;
    } exp_t;

    exp_t sb[$];

    mux_stim_checker dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .probe    (probe),
        .S        (S),
        .I0       (I0),
        .I1       (I1),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .fail_vec (fail_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode 0: good mux, 1: probe[8]=(I1&S)|I0, 2: probe[5] stuck at 0
    always_comb begin
        probe = {(S ? I1 : I0), I0, (I1 & S), 1'b1, S, S, S, I1, I0};
        if (mode == 1) probe[8] = (I1 & S) | I0;
        if (mode == 2) probe[5] = 1'b0;
    end

    function automatic exp_t expect_for(input int m);
        exp_t e;
        e = '{fv: 8'h00, ec: 4'd0, ps: 1'b1};
        if (m == 1) e = '{fv: 8'h20, ec: 4'd1, ps: 1'b0};
`ifdef MUX_PROBE_FULL_CHECK_EN
        if (m == 2) e = '{fv: 8'hFF, ec: 4'd8, ps: 1'b0};
`endif
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stim"}, {29'd0, S, I1, I0}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
        chk({tag, "_err"},  {28'd0, err_cnt}, 32'd0);
        chk({tag, "_fv"},   {24'd0, fail_vec}, 32'd0);
    endtask

    task automatic chk_result(input string tag);
        exp_t x;
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_idle_stim"}, {29'd0, S, I1, I0}, 32'd0);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            x = sb.pop_front();
            chk({tag, "_fv"},   {24'd0, fail_vec}, {24'd0, x.fv});
            chk({tag, "_err"},  {28'd0, err_cnt}, {28'd0, x.ec});
            chk({tag, "_pass"}, {31'd0, pass}, {31'd0, x.ps});
        end
        chk({tag, "_popcnt"}, {28'd0, err_cnt}, $countones(fail_vec));
    endtask

    // Leaves start high when hold is set.
    task automatic run_sweep(input string tag, input int m, input bit hold, input bit repulse);
        mode  = m;
        start = 1'b1;
        sb.push_back(expect_for(m));
        step();
        if (!hold) start = 1'b0;
        chk({tag, "_clr_fv"},   {24'd0, fail_vec}, 32'd0);
        chk({tag, "_clr_err"},  {28'd0, err_cnt}, 32'd0);
        chk({tag, "_clr_pass"}, {31'd0, pass}, 32'd0);
        for (int e = 0; e < 16; e++) begin
            chk({tag, "_vec"},  {29'd0, S, I1, I0}, e / 2);
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_done"}, {31'd0, done}, 32'd0);
            if (!hold) start = repulse && (e == 5);
            step();
        end
        chk_result(tag);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        mode   = 0;
        start  = 1'b0;
        rst_n  = 1'b0;

        step();
        step();
        chk_all_zero("reset");
        #2 rst_n = 1'b1;

        run_sweep("good", 0, 1'b0, 1'b0);
        run_sweep("mux_fault", 1, 1'b0, 1'b0);
        run_sweep("bit5_stuck", 2, 1'b0, 1'b0);
        run_sweep("repulse", 0, 1'b0, 1'b1);

        run_sweep("pre_rst", 1, 1'b0, 1'b0);
        step();
        chk("hold_done_fv", {24'd0, fail_vec}, 32'h20);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_done");
        step();
        #2 rst_n = 1'b1;

        mode  = 2;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 7; e++) step();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        chk("mid_vec", {29'd0, S, I1, I0}, 32'd3);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_mid");
        step();
        chk_all_zero("rst_held");
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step();
        chk_all_zero("no_start");
        run_sweep("after_rst", 0, 1'b0, 1'b0);

        run_sweep("hold", 0, 1'b1, 1'b0);
        sb.push_back(expect_for(0));
        step();
        chk("hold_restart_busy", {31'd0, busy}, 32'd1);
        chk("hold_restart_done", {31'd0, done}, 32'd0);
        chk("hold_restart_vec", {29'd0, S, I1, I0}, 32'd0);
        start = 1'b0;
        for (int e = 1; e < 16; e++) step();
        chk("hold2_pre_done", {31'd0, done}, 32'd0);
        step();
        chk_result("hold2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_stim_checker.md
MUX_STIM_CHECKER -- requirements
Module: mux_stim_checker

Interface
REQ-001: clk  input  1  single system clock; all state updates on rising edge.
REQ-002: rst_n  input  1  reset, asynchronous and active-low; one clock only.
REQ-003: start  input  1  one-cycle request to run a full exhaustive sweep; ignored unless in IDLE or DONE.
REQ-004: probe  input  9  downstream 2:1 mux probe bus; combinational response to S/I0/I1.
REQ-005: S  output  1  select driven into the mux under test.
REQ-006: I0  output  1  data input 0 driven into the mux under test.
REQ-007: I1  output  1  data input 1 driven into the mux under test.
REQ-008: busy  output  1  high while a sweep is in progress.
REQ-009: done  output  1  high in DONE state until the next start or reset.
REQ-010: pass  output  1  valid when done=1; 1 iff err_cnt==0.
REQ-011: err_cnt  output  4  number of failing vectors in the last sweep, range 0..8, saturating never needed.
REQ-012: fail_vec  output  8  bit v set iff vector v failed.

Function
REQ-013: Vector index v (3-bit counter) SHALL map S=v[2], I1=v[1], I0=v[0]; sweep order v=0..7 ascending.
REQ-014: FSM states SHALL be IDLE, DRIVE, SAMPLE, DONE.
REQ-015: IDLE/DONE + start=1 -> DRIVE with v=0, err_cnt=0, fail_vec=0, done=0, pass=0.
REQ-016: DRIVE SHALL present vector v on S/I0/I1 for one cycle, then -> SAMPLE; S/I0/I1 held stable through SAMPLE.
REQ-017: SAMPLE SHALL compare probe against expected; on mismatch set fail_vec[v] and increment err_cnt.
REQ-018: SAMPLE with v<7 -> DRIVE with v+1; SAMPLE with v==7 -> DONE.
REQ-019: Expected probe[8] SHALL be golden mux function S ? I1 : I0.
REQ-020: Sweep latency: start sampled high at edge 0 -> done=1 after edge 16 (8 vectors x 2 cycles).
REQ-021: busy SHALL be 1 in DRIVE and SAMPLE, 0 in IDLE and DONE.
REQ-022: start asserted while busy SHALL be ignored; running sweep is not restarted.
REQ-023: start in DONE SHALL clear results and begin a new sweep on the same edge rule as REQ-015.
REQ-024: In IDLE and DONE, S/I0/I1 SHALL be driven 0.
REQ-025: Mismatch count SHALL equal popcount(fail_vec) at all times.

Reset
REQ-026: rst_n low SHALL immediately force IDLE, v=0, S=I0=I1=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0.
REQ-027: Reset asserted mid-sweep SHALL abandon the sweep; no partial results retained; start required after release.
REQ-028: First start honoured on the first rising edge after rst_n deasserts.

Configuration
REQ-029: Macro MUX_PROBE_FULL_CHECK_EN defined: SAMPLE SHALL compare all 9 probe bits against expected {S?I1:I0, I0, I1&S, 1, S, S, S, I1, I0} (bit 8 down to bit 0).
REQ-030: Macro MUX_PROBE_FULL_CHECK_EN undefined: SAMPLE SHALL compare probe[8] only; probe[7:0] ignored.

Verification
REQ-031: Correct mux model (all 9 bits per REQ-029), pulse start -> done=1 at edge 16, pass=1, err_cnt=0, fail_vec=8'h00 (both macro settings).
REQ-032: Model with probe[8]=(I1&S)|I0 -> vector 1 (S=0,I1=0,I0=1) passes, vector 5 (S=1,I1=0,I0=1) fails: fail_vec=8'h20, err_cnt=1, pass=0.
REQ-033: Correct probe[8] but probe[5] stuck 0 -> macro defined: fail_vec=8'hFF, err_cnt=8; macro undefined: fail_vec=8'h00, pass=1.
REQ-034: rst_n pulsed low at edge 7 of a sweep -> all outputs 0 asynchronously, state IDLE; subsequent start yields full 16-cycle sweep.
REQ-035: start held high continuously -> only one sweep per DONE entry; start re-pulsed at cycle 5 of sweep has no effect on fail_vec/err_cnt/timing.
